avalon_wait_mem: RTL and testbench

Avalon-MM slave memory sitting directly downstream of `top_level_cpu` on its memory bus, replacing the zero-intelligence RAM model in CPU testbenches. It serves word-aligned reads and byte-enabled writes with a fixed, parameterised number of wait states, so CPU stall logic is exercised deterministically. A side-band preload port lets the bench write instruction/data words into the array while the CPU is held in reset.

---
 rtl/avalon_mem_pkg.sv | 30 +++
 rtl/byte_lane_mem.sv | 44 ++++
 rtl/avalon_wait_mem.sv | 106 ++++++++++
 tb/tb_avalon_wait_mem.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_mem_pkg.sv
// Shared types and helpers for the wait-state Avalon-MM memory model.
// Word indexing and byte-lane merging live here so the top and array agree.
package avalon_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    function automatic logic [29:0] word_index(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lanes
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/byte_lane_mem.sv
// 32-bit word array with per-lane bus writes, a full-word preload path and a
// registered read port. The array itself is never reset; only the read register is.
module byte_lane_mem
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            wr_lanes,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    input  logic                  rd_en,
    input  logic                  rd_clear,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [31:0]           rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    // Preload is written last so it overrides a bus write to the same word on the same edge.
    always_ff @(posedge clk) begin
        if (wr_lanes != 4'b0000) begin
            mem[wr_addr] <= lane_merge(mem[wr_addr], wr_data, wr_lanes);
        end
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_clear ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/avalon_wait_mem.sv
// Avalon-MM slave memory with a fixed number of wait states per access,
// plus a side-band preload port for filling the array while the CPU is held in reset.
module avalon_wait_mem
    import avalon_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t                  state;
    logic [3:0]              cnt;
    logic                    request;
    logic                    aligned;
    logic                    enter_ack;
    logic [29:0]             word_all;
    logic                    unused_upper;
    logic [ADDR_WIDTH-1:0]   word_sel;
    logic [3:0]              commit_lanes;
    logic                    rd_en;

    assign request      = read | write;
    assign aligned      = (address[1:0] == 2'b00);
    assign word_all     = word_index(address);
    assign word_sel     = word_all[ADDR_WIDTH-1:0];
    assign unused_upper = ^word_all;

    assign waitrequest  = request && (state != ACK);

    // The read result is captured on the same edge that moves the FSM into ACK.
    assign enter_ack    = request && (((state == IDLE) && (WAIT_CYCLES == 1)) ||
                                      ((state == BUSY) && (cnt == LAST_CNT)));
    assign rd_en        = enter_ack && read && !write;

    assign commit_lanes = ((state == ACK) && write && aligned) ? byteenable : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (WAIT_CYCLES == 1) begin
                            state <= ACK;
                        end else begin
                            state <= BUSY;
                            cnt   <= 4'd1;
                        end
                    end
                end
                BUSY: begin
                    if (!request) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == LAST_CNT) begin
                        state <= ACK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    byte_lane_mem #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk      (clk),
        .reset    (reset),
        .wr_lanes (commit_lanes),
        .wr_addr  (word_sel),
        .wr_data  (writedata),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .rd_en    (rd_en),
        .rd_clear (!aligned),
        .rd_addr  (word_sel),
        .rd_data  (readdata)
    );

endmodule

// File: tb/tb_avalon_wait_mem.sv
// Bench for avalon_wait_mem: fixed vector table, hand-written corner sequences,
// and random accesses checked against a word-array model; a second instance covers WAIT_CYCLES=1.
module tb_avalon_wait_mem;

    localparam int AW = 8;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   address, writedata, readdata, load_data;
    logic          read, write, waitrequest, load_en;
    logic [3:0]    byteenable;
    logic [AW-1:0] load_addr;

    logic [31:0]   address_1, writedata_1, readdata_1, load_data_1;
    logic          read_1, write_1, waitrequest_1, load_en_1;
    logic [3:0]    byteenable_1;
    logic [AW-1:0] load_addr_1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [0:(1<<AW)-1];
    logic [31:0] model_rd;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    avalon_wait_mem #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    avalon_wait_mem #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) dut_1 (
        .clk(clk), .reset(reset), .address(address_1), .read(read_1), .write(write_1),
        .writedata(writedata_1), .byteenable(byteenable_1), .waitrequest(waitrequest_1),
        .readdata(readdata_1), .load_en(load_en_1), .load_addr(load_addr_1), .load_data(load_data_1)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Holds the request until waitrequest falls; leaves it asserted so a caller can chain accesses.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  output int lat, output logic [31:0] rdata);
        bit done;
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = wdata;
        byteenable = be;
        lat   = 0;
        done  = 0;
        rdata = '0;
        while (!done && lat <= 20) begin
            @(negedge clk);
            if (!waitrequest) begin
                done  = 1;
                rdata = readdata;
            end else begin
                lat++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_bus();
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        model_mem[a] = d;
    endtask

    // Reference behaviour: byte-granular word array plus the last completed read value.
    task automatic model_access(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
        int idx;
        idx = int'(addr[AW+1:2]);
        if (wr) begin
            if (addr[1:0] == 2'b00) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else if (rd) begin
            model_rd = (addr[1:0] == 2'b00) ? model_mem[idx] : 32'h0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          n;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [AW-1:0] word;
        int          kind;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          4'b0000, 32'h2403_0020};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hAABB_CCDD,  4'b0101, 32'h2403_0020};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          4'b0000, 32'h11BB_33DD};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0008, 32'h0,          4'b0000, 32'h11BB_33DD};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          4'b0000, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0006, 32'h0,          4'b0000, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_000A, 32'hFFFF_FFFF,  4'b1111, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,          4'b0000, 32'h11BB_33DD};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_0004, 32'h5566_7788,  4'b1010, 32'h11BB_33DD};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          4'b0000, 32'h5503_7720};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0,          4'b0000, 32'h5503_7720};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_000C, 32'hCAFE_F00D,  4'b1111, 32'h5503_7720};
        vecs[12] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,          4'b0000, 32'hCAFE_F00D};

        reset = 1'b0;
        read = 0; write = 0; address = 0; writedata = 0; byteenable = 0;
        load_en = 0; load_addr = 0; load_data = 0;
        read_1 = 0; write_1 = 0; address_1 = 0; writedata_1 = 0; byteenable_1 = 0;
        load_en_1 = 0; load_addr_1 = 0; load_data_1 = 0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_waitrequest", {31'b0, waitrequest}, 32'h0);
        check_output("reset_readdata", readdata, 32'h0);
        read = 1'b1;
        #1;
        check_output("reset_wait_with_req", {31'b0, waitrequest}, 32'h1);
        read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("post_reset_readdata", readdata, 32'h0);

        // Fixed vector table, issued back-to-back with no idle gaps.
        preload(8'd1, 32'h2403_0020);
        preload(8'd2, 32'h1122_3344);
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rdata);
            check_output($sformatf("vec%0d_latency", i), lat, WC);
            check_output($sformatf("vec%0d_readdata", i), rdata, vecs[i].exp_rd);
        end
        idle_bus();
        @(posedge clk);
        #1;

        // Request withdrawn while still waiting: no memory effect.
        preload(8'd6, 32'h600D_CAFE);
        write = 1'b1; address = 32'h18; writedata = 32'hFFFF_FFFF; byteenable = 4'hF;
        @(negedge clk);
        check_output("drop_wait_high", {31'b0, waitrequest}, 32'h1);
        @(posedge clk);
        #1;
        write = 1'b0;
        @(negedge clk);
        check_output("drop_wait_low", {31'b0, waitrequest}, 32'h0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 32'h18, 32'h0, 4'h0, lat, rdata);
        check_output("drop_read_latency", lat, WC);
        check_output("drop_read_data", rdata, 32'h600D_CAFE);
        idle_bus();

        // Reset during the wait phase of a write discards it and clears readdata.
        preload(8'd4, 32'h0BAD_F00D);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rdata);
        check_output("pre_reset_read", rdata, 32'h0BAD_F00D);
        write = 1'b1; read = 1'b0; address = 32'h10; writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("midreset_readdata", readdata, 32'h0);
        check_output("midreset_wait", {31'b0, waitrequest}, 32'h1);
        write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rdata);
        check_output("midreset_mem_kept", rdata, 32'h0BAD_F00D);
        idle_bus();

        // Preload and bus write to the same word on the same edge.
        preload(8'd5, 32'h0);
        write = 1'b1; address = 32'h14; writedata = 32'h2; byteenable = 4'hF;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!waitrequest) break;
        end
        check_output("collide_latency", n, WC);
        load_en = 1'b1; load_addr = 8'd5; load_data = 32'h1;
        @(posedge clk);
        #1;
        load_en = 1'b0;
        model_mem[5] = 32'h1;
        apply_stimulus(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, rdata);
        check_output("collide_read", rdata, 32'h1);
        idle_bus();
        @(posedge clk);
        #1;

        // Random traffic over 16 words against the model.
        for (int w = 0; w < 16; w++) preload(AW'(w), $urandom);
        model_rd = 32'h1;
        for (int i = 0; i < 80; i++) begin
            logic rd_b, wr_b;
            logic [31:0] wd;
            logic [3:0]  be;
            kind = $urandom_range(0, 2);
            rd_b = (kind != 1);
            wr_b = (kind != 0);
            word = AW'($urandom_range(0, 15));
            addr = $urandom;
            addr[AW+1:2] = word;
            addr[1:0] = (kind == 0 && $urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            wd = $urandom;
            be = 4'($urandom);
            apply_stimulus(rd_b, wr_b, addr, wd, be, lat, rdata);
            model_access(rd_b, wr_b, addr, wd, be);
            check_output($sformatf("rand%0d_latency", i), lat, WC);
            check_output($sformatf("rand%0d_readdata", i), rdata, model_rd);
            if ($urandom_range(0, 3) == 0) begin
                idle_bus();
                @(posedge clk);
                #1;
            end
        end
        idle_bus();
        @(posedge clk);
        #1;

        // Single-wait-state instance.
        load_en_1 = 1'b1; load_addr_1 = 8'd1; load_data_1 = 32'h2403_0020;
        @(posedge clk);
        #1;
        load_en_1 = 1'b0;
        read_1 = 1'b1; address_1 = 32'h4;
        @(negedge clk);
        check_output("w1_read_wait", {31'b0, waitrequest_1}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("w1_read_ack", {31'b0, waitrequest_1}, 32'h0);
        check_output("w1_read_data", readdata_1, 32'h2403_0020);
        @(posedge clk);
        #1;
        address_1 = 32'h6;
        @(negedge clk);
        check_output("w1_mis_wait", {31'b0, waitrequest_1}, 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("w1_mis_ack", {31'b0, waitrequest_1}, 32'h0);
        check_output("w1_mis_data", readdata_1, 32'h0);
        @(posedge clk);
        #1;
        read_1 = 1'b0;
        @(negedge clk);
        check_output("w1_idle_wait", {31'b0, waitrequest_1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
